// File: rtl/lc3_mem_port_if.sv
// Bus/SRAM signal bundle between the ISDU-driven datapath and lc3_mem_port.
// Latency: none, wires only.
// Backpressure: none here; the port reports completion with R and holds BUSY during an access.
interface lc3_mem_port_if #(
  parameter int N = 16
);
  logic [N-1:0] BUS;
  logic         LD_MAR;
  logic         LD_MDR;
  logic         MEM_RD;
  logic         MEM_WR;
  logic [N-1:0] MAR;
  logic [N-1:0] MDR;
  logic         R;
  logic         BUSY;
  logic [N-1:0] ADDR;
  logic [N-1:0] Data_to_SRAM;
  logic [N-1:0] Data_from_SRAM;
  logic         CE_N;
  logic         OE_N;
  logic         WE_N;

  // Datapath / control side
  modport master (
    output BUS, LD_MAR, LD_MDR, MEM_RD, MEM_WR, Data_from_SRAM,
    input  MAR, MDR, R, BUSY, ADDR, Data_to_SRAM, CE_N, OE_N, WE_N
  );

  // Memory port side
  modport slave (
    input  BUS, LD_MAR, LD_MDR, MEM_RD, MEM_WR, Data_from_SRAM,
    output MAR, MDR, R, BUSY, ADDR, Data_to_SRAM, CE_N, OE_N, WE_N
  );
endinterface

// File: rtl/lc3_mem_port.sv
// MAR/MDR capture plus single-word SRAM read/write sequencer with WAIT_CYCLES wait states.
// Latency: read R pulse WAIT_CYCLES+1 cycles after request edge, write WAIT_CYCLES+2.
// Backpressure: BUSY high outside IDLE; loads and requests are ignored while BUSY.
// Optional: define LC3_MEM_PORT_ERR_EN to add the sticky ERR protocol-violation flag.
module lc3_mem_port #(
  parameter int N           = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            Clk,
  input  logic            Reset_n,
  lc3_mem_port_if.slave   mp
`ifdef LC3_MEM_PORT_ERR_EN
  ,
  output logic            ERR
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t       state_q;
  state_t       state_n;
  logic [3:0]   cnt_q;
  logic [N-1:0] mar_q;
  logic [N-1:0] mdr_q;

  // Conflicting read+write requests start nothing.
  logic start_rd;
  logic start_wr;
  assign start_rd = (state_q == IDLE) && mp.MEM_RD && !mp.MEM_WR;
  assign start_wr = (state_q == IDLE) && mp.MEM_WR && !mp.MEM_RD;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (start_rd)      state_n = RD;
        else if (start_wr) state_n = WR_SETUP;
      end
      RD:       if (cnt_q == 4'd0) state_n = DONE;
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: if (cnt_q == 4'd0) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Wait-state counter: loaded on entry to a timed phase, counts down to 0
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE:         if (start_rd) cnt_q <= CNT_INIT;
        WR_SETUP:     cnt_q <= CNT_INIT;
        RD, WR_PULSE: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        default:      cnt_q <= cnt_q;
      endcase
    end
  end

  // MAR/MDR: bus loads only in IDLE, read data captured on the last RD cycle
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else if (state_q == IDLE) begin
      if (mp.LD_MAR) mar_q <= mp.BUS;
      if (mp.LD_MDR) mdr_q <= mp.BUS;
    end else if ((state_q == RD) && (cnt_q == 4'd0)) begin
      mdr_q <= mp.Data_from_SRAM;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    mp.CE_N = 1'b1;
    mp.OE_N = 1'b1;
    mp.WE_N = 1'b1;
    mp.R    = 1'b0;
    case (state_q)
      RD: begin
        mp.CE_N = 1'b0;
        mp.OE_N = 1'b0;
      end
      WR_SETUP: mp.CE_N = 1'b0;
      WR_PULSE: begin
        mp.CE_N = 1'b0;
        mp.WE_N = 1'b0;
      end
      DONE:     mp.R = 1'b1;
      default:  ;
    endcase
    mp.BUSY         = (state_q != IDLE);
    mp.MAR          = mar_q;
    mp.MDR          = mdr_q;
    mp.ADDR         = mar_q;
    mp.Data_to_SRAM = mdr_q;
  end

`ifdef LC3_MEM_PORT_ERR_EN
  logic any_strobe;
  logic violation;
  assign any_strobe = mp.LD_MAR | mp.LD_MDR | mp.MEM_RD | mp.MEM_WR;
  assign violation  = ((state_q == IDLE) && mp.MEM_RD && mp.MEM_WR) ||
                      ((state_q != IDLE) && (state_q != DONE) && any_strobe);

  // Sticky violation flag, cleared only by reset
  always_ff @(posedge Clk) begin
    if (!Reset_n)       ERR <= 1'b0;
    else if (violation) ERR <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_lc3_mem_port.sv
// Directed self-checking bench for lc3_mem_port: instance A with WAIT_CYCLES=2, instance B with 1.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Both instances see identical stimulus; B is only checked in the reset/short-wait step.
module tb_lc3_mem_port;
  logic        Clk;
  logic        Reset_n;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mem_rd, mem_wr;
  logic [15:0] dfs;
  int          checks;
  int          errors;

  lc3_mem_port_if #(.N(16)) ia ();
  lc3_mem_port_if #(.N(16)) ib ();

  assign ia.BUS = bus;            assign ib.BUS = bus;
  assign ia.LD_MAR = ld_mar;      assign ib.LD_MAR = ld_mar;
  assign ia.LD_MDR = ld_mdr;      assign ib.LD_MDR = ld_mdr;
  assign ia.MEM_RD = mem_rd;      assign ib.MEM_RD = mem_rd;
  assign ia.MEM_WR = mem_wr;      assign ib.MEM_WR = mem_wr;
  assign ia.Data_from_SRAM = dfs; assign ib.Data_from_SRAM = dfs;

`ifdef LC3_MEM_PORT_ERR_EN
  logic err_a, err_b;
  lc3_mem_port #(.N(16), .WAIT_CYCLES(2)) dut_a (.Clk(Clk), .Reset_n(Reset_n), .mp(ia), .ERR(err_a));
  lc3_mem_port #(.N(16), .WAIT_CYCLES(1)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .mp(ib), .ERR(err_b));
`else
  lc3_mem_port #(.N(16), .WAIT_CYCLES(2)) dut_a (.Clk(Clk), .Reset_n(Reset_n), .mp(ia));
  lc3_mem_port #(.N(16), .WAIT_CYCLES(1)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .mp(ib));
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {CE_N, OE_N, WE_N} of instance A / B
  function automatic logic [31:0] stb_a();
    return {29'd0, ia.CE_N, ia.OE_N, ia.WE_N};
  endfunction
  function automatic logic [31:0] stb_b();
    return {29'd0, ib.CE_N, ib.OE_N, ib.WE_N};
  endfunction

  initial begin
    checks = 0; errors = 0;
    Reset_n = 1'b0; bus = '0; ld_mar = 0; ld_mdr = 0; mem_rd = 0; mem_wr = 0; dfs = '0;
    tick(); tick();
    chk("rst_mar",  ia.MAR,  0);
    chk("rst_mdr",  ia.MDR,  0);
    chk("rst_r",    ia.R,    0);
    chk("rst_busy", ia.BUSY, 0);
    chk("rst_stb",  stb_a(), 32'b111);
`ifdef LC3_MEM_PORT_ERR_EN
    chk("rst_err",  err_a,   0);
`endif
    Reset_n = 1'b1;

    // 1: load MAR
    bus = 16'h3000; ld_mar = 1; tick(); ld_mar = 0;
    chk("t1_mar",  ia.MAR,  16'h3000);
    chk("t1_addr", ia.ADDR, 16'h3000);
    chk("t1_mdr",  ia.MDR,  0);
    chk("t1_r",    ia.R,    0);
    chk("t1_stb",  stb_a(), 32'b111);

    // 2: read, WAIT_CYCLES=2
    dfs = 16'hBEEF; mem_rd = 1; tick(); mem_rd = 0;
    chk("t2_c1_stb",  stb_a(), 32'b001);
    chk("t2_c1_busy", ia.BUSY, 1);
    chk("t2_c1_r",    ia.R,    0);
    tick();
    chk("t2_c2_stb",  stb_a(), 32'b001);
    chk("t2_c2_r",    ia.R,    0);
    tick();
    chk("t2_c3_r",    ia.R,    1);
    chk("t2_c3_stb",  stb_a(), 32'b111);
    chk("t2_c3_mdr",  ia.MDR,  16'hBEEF);
    tick();
    chk("t2_c4_r",    ia.R,    0);
    chk("t2_c4_busy", ia.BUSY, 0);

    // 3: write
    bus = 16'h0010; ld_mar = 1; tick(); ld_mar = 0;
    bus = 16'h1234; ld_mdr = 1; tick(); ld_mdr = 0;
    mem_wr = 1; tick(); mem_wr = 0;
    chk("t3_c1_stb",  stb_a(), 32'b011);
    chk("t3_c1_dat",  ia.Data_to_SRAM, 16'h1234);
    chk("t3_c1_addr", ia.ADDR, 16'h0010);
    tick();
    chk("t3_c2_stb",  stb_a(), 32'b010);
    chk("t3_c2_dat",  ia.Data_to_SRAM, 16'h1234);
    tick();
    chk("t3_c3_stb",  stb_a(), 32'b010);
    chk("t3_c3_r",    ia.R,    0);
    tick();
    chk("t3_c4_r",    ia.R,    1);
    chk("t3_c4_stb",  stb_a(), 32'b111);
    chk("t3_c4_mdr",  ia.MDR,  16'h1234);
    tick();
    chk("t3_c5_r",    ia.R,    0);

    // 4: loads/requests during a read are ignored
    bus = 16'h3000; ld_mar = 1; tick(); ld_mar = 0;
    mem_rd = 1; tick(); mem_rd = 0;
`ifdef LC3_MEM_PORT_ERR_EN
    chk("t4_err_pre", err_a, 0);
`endif
    bus = 16'hFFFF; ld_mar = 1; mem_wr = 1; tick(); ld_mar = 0; mem_wr = 0;
    chk("t4_c2_mar", ia.MAR, 16'h3000);
    chk("t4_c2_stb", stb_a(), 32'b001);
`ifdef LC3_MEM_PORT_ERR_EN
    chk("t4_err_set", err_a, 1);
`endif
    tick();
    chk("t4_c3_r",    ia.R,    1);
    tick();
    chk("t4_c4_r",    ia.R,    0);
    chk("t4_c4_busy", ia.BUSY, 0);
    chk("t4_c4_mar",  ia.MAR,  16'h3000);
    tick();
    chk("t4_c5_busy", ia.BUSY, 0);
    chk("t4_c5_stb",  stb_a(), 32'b111);
`ifdef LC3_MEM_PORT_ERR_EN
    chk("t4_err_hold", err_a, 1);
`endif

    // 5: conflicting requests in IDLE (reset first to clear any sticky flag)
    Reset_n = 0; tick(); Reset_n = 1;
    mem_rd = 1; mem_wr = 1; tick();
    chk("t5_c1_busy", ia.BUSY, 0);
    chk("t5_c1_stb",  stb_a(), 32'b111);
    tick(); mem_rd = 0; mem_wr = 0;
    chk("t5_c2_r",    ia.R,    0);
    chk("t5_c2_busy", ia.BUSY, 0);
    tick();
    chk("t5_c3_r",    ia.R,    0);
    chk("t5_c3_stb",  stb_a(), 32'b111);
`ifdef LC3_MEM_PORT_ERR_EN
    chk("t5_err", err_a, 1);
`endif

    // 6: reset in 2nd RD cycle, then a clean read on both instances
    bus = 16'h0040; ld_mar = 1; tick(); ld_mar = 0;
    dfs = 16'h5A5A; mem_rd = 1; tick(); mem_rd = 0;
    tick();
    chk("t6_rd2_stb", stb_a(), 32'b001);
    Reset_n = 0; tick();
    chk("t6_rst_stb",  stb_a(), 32'b111);
    chk("t6_rst_mar",  ia.MAR,  0);
    chk("t6_rst_mdr",  ia.MDR,  0);
    chk("t6_rst_r",    ia.R,    0);
    chk("t6_rst_busy", ia.BUSY, 0);
`ifdef LC3_MEM_PORT_ERR_EN
    chk("t6_rst_err",  err_a,   0);
`endif
    Reset_n = 1;
    mem_rd = 1; tick(); mem_rd = 0;
    chk("t6_b_c1_stb", stb_b(), 32'b001);
    chk("t6_b_c1_r",   ib.R,    0);
    tick();
    chk("t6_b_c2_r",   ib.R,    1);
    chk("t6_b_c2_mdr", ib.MDR,  16'h5A5A);
    chk("t6_a_c2_r",   ia.R,    0);
    tick();
    chk("t6_b_c3_r",   ib.R,    0);
    chk("t6_a_c3_r",   ia.R,    1);
    chk("t6_a_c3_mdr", ia.MDR,  16'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
